// File: rtl/power_engine_pkg.sv
// Shared types and constants for the iterative power engine.
package power_engine_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POW1  = 3'd1,
        DERIV = 3'd2,
        MUL_I = 3'd3,
        POW2  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [MODE_W-1:0] MODE_F    = 2'd0;
    localparam logic [MODE_W-1:0] MODE_FD   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_FULL = 2'd2;
    localparam logic [MODE_W-1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/ovf_multiplier.sv
// WIDTH x WIDTH multiplier returning the low WIDTH bits and a flag for a nonzero upper half.
module ovf_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_prod_c,
    output logic             o_ovf_c
);

    logic [2*WIDTH-1:0] w_full;

    always_comb begin
        w_full   = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
        o_prod_c = w_full[WIDTH-1:0];
        o_ovf_c  = |w_full[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/iterative_power_engine.sv
// Handshaked multi-cycle engine computing it^n, n*it^(n-1) and (i*f')^n mod 2^WIDTH
// with LSB-first square-and-multiply and overflow tracking.
module iterative_power_engine
    import power_engine_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MODE_W-1:0]    in_mode,
    input  logic [WIDTH-1:0]     in_i,
    input  logic [WIDTH-1:0]     in_it,
    input  logic [EXP_WIDTH-1:0] in_n,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     f_it,
    output logic [WIDTH-1:0]     f_prime_it,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned STEP_W = $clog2(EXP_WIDTH + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(EXP_WIDTH);

    state_e               r_state;
    logic [STEP_W-1:0]    r_step;
    logic [MODE_W-1:0]    r_mode;
    logic [WIDTH-1:0]     r_i;
    logic [WIDTH-1:0]     r_it;
    logic [EXP_WIDTH-1:0] r_n;
    logic [EXP_WIDTH-1:0] r_e;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_acc_ovf;
    logic [WIDTH-1:0]     r_b;
    logic                 r_b_ovf;
    logic [WIDTH-1:0]     r_f;
    logic                 r_f_ovf;
    logic [WIDTH-1:0]     r_fp;
    logic                 r_fp_ovf;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_f_it;
    logic [WIDTH-1:0]     r_f_prime_it;
    logic [WIDTH-1:0]     r_result;
    logic                 r_overflow;
    logic                 r_err;
    logic                 r_busy;

    logic [WIDTH-1:0]     w_ma_a, w_ma_b, w_pa;
    logic [WIDTH-1:0]     w_mb_a, w_mb_b, w_pb;
    logic                 w_pa_ovf, w_pb_ovf;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic                 w_acc_ovf_nxt;
    logic [WIDTH-1:0]     w_f, w_fp;
    logic                 w_f_ovf, w_fp_ovf;

    // Multiplier A: accumulate, f=acc*it, x=i*f'. Multiplier B: squaring, f'=n*acc.
    always_comb begin
        w_ma_a = '0;
        w_ma_b = '0;
        w_mb_a = '0;
        w_mb_b = '0;
        case (r_state)
            POW1, POW2: begin
                w_ma_a = r_acc;
                w_ma_b = r_b;
                w_mb_a = r_b;
                w_mb_b = r_b;
            end
            DERIV: begin
                w_ma_a = r_acc;
                w_ma_b = r_it;
                w_mb_a = r_acc;
                w_mb_b = WIDTH'(r_n);
            end
            MUL_I: begin
                w_ma_a = r_i;
                w_ma_b = r_fp;
            end
            default: ;
        endcase
    end

    ovf_multiplier #(.WIDTH(WIDTH)) u_mul_acc (
        .i_a      (w_ma_a),
        .i_b      (w_ma_b),
        .o_prod_c (w_pa),
        .o_ovf_c  (w_pa_ovf)
    );

    ovf_multiplier #(.WIDTH(WIDTH)) u_mul_sq (
        .i_a      (w_mb_a),
        .i_b      (w_mb_b),
        .o_prod_c (w_pb),
        .o_ovf_c  (w_pb_ovf)
    );

    // Step result and derivative values; an overflowed b taints any product it enters.
    always_comb begin
        w_acc_nxt     = r_acc;
        w_acc_ovf_nxt = r_acc_ovf;
        if (r_e[0]) begin
            w_acc_nxt     = w_pa;
            w_acc_ovf_nxt = r_acc_ovf | w_pa_ovf | r_b_ovf;
        end
        w_f      = w_pa;
        w_f_ovf  = r_acc_ovf | w_pa_ovf;
        w_fp     = w_pb;
        w_fp_ovf = r_acc_ovf | w_pb_ovf;
        if (r_n == '0) begin
            w_f      = WIDTH'(1);
            w_f_ovf  = 1'b0;
            w_fp     = '0;
            w_fp_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_mode       <= MODE_F;
            r_i          <= '0;
            r_it         <= '0;
            r_n          <= '0;
            r_e          <= '0;
            r_acc        <= '0;
            r_acc_ovf    <= 1'b0;
            r_b          <= '0;
            r_b_ovf      <= 1'b0;
            r_f          <= '0;
            r_f_ovf      <= 1'b0;
            r_fp         <= '0;
            r_fp_ovf     <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_f_it       <= '0;
            r_f_prime_it <= '0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mode     <= in_mode;
                        r_i        <= in_i;
                        r_it       <= in_it;
                        r_n        <= in_n;
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= POW1;
                    end
                end
                POW1, POW2: begin
                    // First POW1 cycle seeds the accumulator and the exponent n-1.
                    if (r_state == POW1 && r_step == '0) begin
                        r_acc     <= WIDTH'(1);
                        r_acc_ovf <= 1'b0;
                        r_b       <= r_it;
                        r_b_ovf   <= 1'b0;
                        r_e       <= (r_n == '0) ? '0 : r_n - EXP_WIDTH'(1);
                        r_step    <= STEP_W'(1);
                    end else begin
                        r_acc     <= w_acc_nxt;
                        r_acc_ovf <= w_acc_ovf_nxt;
                        r_b       <= w_pb;
                        r_b_ovf   <= r_b_ovf | w_pb_ovf;
                        r_e       <= r_e >> 1;
                        r_step    <= r_step + STEP_W'(1);
                        if (r_step == LAST_STEP) begin
                            if (r_state == POW1) begin
                                r_state <= DERIV;
                            end else begin
                                r_f_it       <= r_f;
                                r_f_prime_it <= r_fp;
                                r_result     <= w_acc_nxt;
                                r_overflow   <= r_f_ovf | r_fp_ovf | w_acc_ovf_nxt;
                                r_err        <= 1'b0;
                                r_out_valid  <= 1'b1;
                                r_state      <= DONE;
                            end
                        end
                    end
                end
                DERIV: begin
                    r_f      <= w_f;
                    r_f_ovf  <= w_f_ovf;
                    r_fp     <= w_fp;
                    r_fp_ovf <= w_fp_ovf;
                    if (r_mode == MODE_FULL) begin
                        r_state <= MUL_I;
                    end else begin
                        r_f_it       <= (r_mode == MODE_RSVD) ? '0 : w_f;
                        r_f_prime_it <= (r_mode == MODE_FD) ? w_fp : '0;
                        r_result     <= '0;
                        r_overflow   <= (r_mode == MODE_F)  ? w_f_ovf :
                                        (r_mode == MODE_FD) ? (w_f_ovf | w_fp_ovf) : 1'b0;
                        r_err        <= (r_mode == MODE_RSVD);
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                MUL_I: begin
                    // x = i*f' becomes the base of the second exponentiation.
                    r_acc     <= WIDTH'(1);
                    r_acc_ovf <= 1'b0;
                    r_b       <= w_pa;
                    r_b_ovf   <= r_fp_ovf | w_pa_ovf;
                    r_e       <= r_n;
                    r_step    <= STEP_W'(1);
                    r_state   <= POW2;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign f_it       = r_f_it;
    assign f_prime_it = r_f_prime_it;
    assign result     = r_result;
    assign overflow   = r_overflow;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_iterative_power_engine.sv
// Directed self-checking bench for iterative_power_engine (WIDTH=32, EXP_WIDTH=8).
module tb_iterative_power_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_i;
    logic [31:0] in_it;
    logic [7:0]  in_n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f_it;
    logic [31:0] f_prime_it;
    logic [31:0] result;
    logic        overflow;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int lat;

    iterative_power_engine #(.WIDTH(32), .EXP_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_i       (in_i),
        .in_it      (in_it),
        .in_n       (in_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f_it       (f_it),
        .f_prime_it (f_prime_it),
        .result     (result),
        .overflow   (overflow),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Presents one op, waits for the accepting edge, then scrambles inputs.
    task automatic start_op(input logic [1:0] m, input logic [31:0] i, input logic [31:0] it,
                            input logic [7:0] n);
        in_valid = 1'b1;
        in_mode  = m;
        in_i     = i;
        in_it    = it;
        in_n     = n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'd3;
        in_i     = 32'hFFFF_FFFF;
        in_it    = 32'hFFFF_FFFF;
        in_n     = 8'hFF;
    endtask

    // Counts edges from the accepting edge until out_valid, bounded.
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (f_it !== 32'd0) begin errors++; $display("FAIL reset_f_it: got %0h expected 0", f_it); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0h expected 0", result); end
        checks++; if ({overflow, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %03b expected 000", {overflow, err, busy}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_mode1();
        start_op(2'd1, 32'd0, 32'd3, 8'd4);
        checks++; if ({in_ready, busy} !== 2'b01) begin errors++; $display("FAIL m1_accept_flags: got %02b expected 01", {in_ready, busy}); end
        wait_out(lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL m1_latency: got %0d expected 10", lat); end
        checks++; if (f_it !== 32'd81) begin errors++; $display("FAIL m1_f_it: got %0d expected 81", f_it); end
        checks++; if (f_prime_it !== 32'd108) begin errors++; $display("FAIL m1_f_prime: got %0d expected 108", f_prime_it); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL m1_result: got %0d expected 0", result); end
        checks++; if ({overflow, err} !== 2'b00) begin errors++; $display("FAIL m1_flags: got %02b expected 00", {overflow, err}); end
        handshake();
    endtask

    task automatic test_mode2();
        start_op(2'd2, 32'd2, 32'd3, 8'd2);
        wait_out(lat);
        checks++; if (lat !== 19) begin errors++; $display("FAIL m2_latency: got %0d expected 19", lat); end
        checks++; if (f_it !== 32'd9) begin errors++; $display("FAIL m2_f_it: got %0d expected 9", f_it); end
        checks++; if (f_prime_it !== 32'd6) begin errors++; $display("FAIL m2_f_prime: got %0d expected 6", f_prime_it); end
        checks++; if (result !== 32'd144) begin errors++; $display("FAIL m2_result: got %0d expected 144", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL m2_overflow: got %0b expected 0", overflow); end
        handshake();
    endtask

    task automatic test_n_zero();
        start_op(2'd2, 32'd7, 32'd5, 8'd0);
        wait_out(lat);
        checks++; if (lat !== 19) begin errors++; $display("FAIL n0_latency: got %0d expected 19", lat); end
        checks++; if (f_it !== 32'd1) begin errors++; $display("FAIL n0_f_it: got %0d expected 1", f_it); end
        checks++; if (f_prime_it !== 32'd0) begin errors++; $display("FAIL n0_f_prime: got %0d expected 0", f_prime_it); end
        checks++; if (result !== 32'd1) begin errors++; $display("FAIL n0_result: got %0d expected 1", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL n0_overflow: got %0b expected 0", overflow); end
        handshake();
    endtask

    task automatic test_mode0_boundary();
        start_op(2'd0, 32'd9, 32'd2, 8'd31);
        wait_out(lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL m0_latency: got %0d expected 10", lat); end
        checks++; if (f_it !== 32'h8000_0000) begin errors++; $display("FAIL m0_n31_f_it: got %0h expected 80000000", f_it); end
        checks++; if ({f_prime_it, result} !== 64'd0) begin errors++; $display("FAIL m0_n31_zero_outs: got %0h/%0h expected 0/0", f_prime_it, result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL m0_n31_overflow: got %0b expected 0", overflow); end
        handshake();
        start_op(2'd0, 32'd0, 32'd2, 8'd40);
        wait_out(lat);
        checks++; if (f_it !== 32'd0) begin errors++; $display("FAIL m0_n40_f_it: got %0h expected 0", f_it); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL m0_n40_overflow: got %0b expected 1", overflow); end
        handshake();
        // 65536^2 wraps to 0 while 2*65536 fits
        start_op(2'd1, 32'd0, 32'h0001_0000, 8'd2);
        wait_out(lat);
        checks++; if (f_it !== 32'd0) begin errors++; $display("FAIL m1_wrap_f_it: got %0h expected 0", f_it); end
        checks++; if (f_prime_it !== 32'h0002_0000) begin errors++; $display("FAIL m1_wrap_f_prime: got %0h expected 20000", f_prime_it); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL m1_wrap_overflow: got %0b expected 1", overflow); end
        handshake();
    endtask

    task automatic test_mode3();
        start_op(2'd3, 32'd5, 32'd3, 8'd2);
        wait_out(lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL m3_latency: got %0d expected 10", lat); end
        checks++; if ({f_it, f_prime_it, result} !== 96'd0) begin errors++; $display("FAIL m3_data: got %0h/%0h/%0h expected 0/0/0", f_it, f_prime_it, result); end
        checks++; if ({err, overflow} !== 2'b10) begin errors++; $display("FAIL m3_flags: got %02b expected 10", {err, overflow}); end
        handshake();
    endtask

    task automatic test_backpressure();
        start_op(2'd1, 32'd0, 32'd3, 8'd4);
        wait_out(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, f_it, f_prime_it} !== {1'b1, 1'b0, 32'd81, 32'd108}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%0b r=%0b f=%0d fp=%0d expected v=1 r=0 f=81 fp=108",
                         k, out_valid, in_ready, f_it, f_prime_it);
            end
        end
        handshake();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_after_hs: got %02b expected 01", {out_valid, in_ready}); end
        checks++; if (f_it !== 32'd81) begin errors++; $display("FAIL bp_retain: got %0d expected 81", f_it); end
    endtask

    task automatic test_back_to_back();
        start_op(2'd1, 32'd0, 32'd5, 8'd3);
        wait_out(lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_latency: got %0d expected 10", lat); end
        checks++; if ({f_it, f_prime_it} !== {32'd125, 32'd75}) begin errors++; $display("FAIL b2b_values: got %0d/%0d expected 125/75", f_it, f_prime_it); end
        handshake();
    endtask

    task automatic test_mid_reset();
        int seen;
        start_op(2'd2, 32'd2, 32'd3, 8'd2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin errors++; $display("FAIL mr_flags: got %03b expected 001", {out_valid, busy, in_ready}); end
        checks++; if ({f_it, f_prime_it, result} !== 96'd0) begin errors++; $display("FAIL mr_outputs: got %0h/%0h/%0h expected 0/0/0", f_it, f_prime_it, result); end
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mr_no_valid: got %0d valid cycles expected 0", seen); end
        start_op(2'd2, 32'd2, 32'd3, 8'd2);
        wait_out(lat);
        checks++; if (lat !== 19) begin errors++; $display("FAIL mr_next_latency: got %0d expected 19", lat); end
        checks++; if (result !== 32'd144) begin errors++; $display("FAIL mr_next_result: got %0d expected 144", result); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mr_next_err: got %0b expected 0", err); end
        handshake();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_i      = 32'd0;
        in_it     = 32'd0;
        in_n      = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_mode1();
        test_mode2();
        test_n_zero();
        test_mode0_boundary();
        test_mode3();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
